// File: rtl/sector_hex_dump_pkg.sv
// Shared types, ASCII constants and the nibble-to-hex helper for the
// sector dump formatter and its sibling debug blocks.
package sd_dump_pkg;

  typedef enum logic [2:0] {
    ST_WAIT = 3'd0,
    ST_HDR  = 3'd1,
    ST_OFS  = 3'd2,
    ST_BYTE = 3'd3,
    ST_EOL  = 3'd4
  } dump_state_t;

  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_COLON = 8'h3A;

  // "SEC " packed most-significant character first
  localparam logic [31:0] SEC_STR = 32'h5345_4320;

  // Index of the final character emitted in each state
  localparam logic [3:0] HDR_LAST  = 4'd13;
  localparam logic [3:0] OFS_LAST  = 4'd3;
  localparam logic [3:0] BYTE_LAST = 4'd2;
  localparam logic [3:0] EOL_LAST  = 4'd1;

  // Uppercase ASCII hex digit for one nibble
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    logic [7:0] chr;
    if (nib < 4'd10) begin
      chr = 8'h30 + {4'h0, nib};
    end else begin
      chr = 8'h37 + {4'h0, nib};
    end
    return chr;
  endfunction

endpackage

// File: rtl/sector_hex_dump.sv
// Converts a sector byte stream into hex-dump text, one ASCII character
// at a time, for a UART write port (wreq/wgnt handshake).
module sector_hex_dump
  import sd_dump_pkg::*;
#(
  parameter int BYTES_PER_LINE = 16,
  parameter bit HEADER_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic [31:0] sector_addr,
  output logic        wreq,
  input  logic        wgnt,
  output logic [7:0]  wdata,
  output logic        busy
);

  localparam int COL_W = $clog2(BYTES_PER_LINE) + 1;
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(BYTES_PER_LINE);
  localparam logic [COL_W-1:0] COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};

  dump_state_t      state_q, state_d;
  logic [3:0]       cidx_q, cidx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [8:0]       offset_q, offset_d;
  logic             sec_start_q, sec_start_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic [31:0]      addr_q, addr_d;
  logic             in_ready_q, in_ready_d;
  logic             wreq_q, wreq_d;
  logic [7:0]       wdata_c;
  logic [COL_W-1:0] col_inc;

  assign col_inc = col_q + COL_ONE;

  // Next-state, character index and line/sector bookkeeping
  always_comb begin
    state_d     = state_q;
    cidx_d      = cidx_q;
    col_d       = col_q;
    offset_d    = offset_q;
    sec_start_d = sec_start_q;
    data_d      = data_q;
    last_d      = last_q;
    addr_d      = addr_q;
    case (state_q)
      ST_WAIT: begin
        if (in_valid) begin
          data_d = in_data;
          last_d = in_last;
          if (sec_start_q) begin
            addr_d = sector_addr;
          end else begin
            addr_d = addr_q;
          end
          if (sec_start_q && HEADER_EN) begin
            state_d = ST_HDR;
          end else if (col_q == COL_ZERO) begin
            state_d = ST_OFS;
          end else begin
            state_d = ST_BYTE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HDR: begin
        if (wgnt && (cidx_q == HDR_LAST)) begin
          cidx_d      = 4'd0;
          state_d     = ST_OFS;
          sec_start_d = 1'b0;
        end else if (wgnt) begin
          cidx_d = cidx_q + 4'd1;
        end else begin
          cidx_d = cidx_q;
        end
      end
      ST_OFS: begin
        // Clearing here covers sectors whose header was suppressed
        if (wgnt && (cidx_q == OFS_LAST)) begin
          cidx_d      = 4'd0;
          state_d     = ST_BYTE;
          sec_start_d = 1'b0;
        end else if (wgnt) begin
          cidx_d = cidx_q + 4'd1;
        end else begin
          cidx_d = cidx_q;
        end
      end
      ST_BYTE: begin
        if (wgnt && (cidx_q == BYTE_LAST)) begin
          cidx_d   = 4'd0;
          offset_d = offset_q + 9'd1;
          col_d    = col_inc;
          if ((col_inc == COL_FULL) || last_q) begin
            state_d = ST_EOL;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (wgnt) begin
          cidx_d = cidx_q + 4'd1;
        end else begin
          cidx_d = cidx_q;
        end
      end
      ST_EOL: begin
        if (wgnt && (cidx_q == EOL_LAST)) begin
          cidx_d  = 4'd0;
          col_d   = COL_ZERO;
          state_d = ST_WAIT;
          if (last_q) begin
            sec_start_d = 1'b1;
            offset_d    = 9'd0;
          end else begin
            sec_start_d = sec_start_q;
          end
        end else if (wgnt) begin
          cidx_d = cidx_q + 4'd1;
        end else begin
          cidx_d = cidx_q;
        end
      end
      default: begin
        state_d = ST_WAIT;
        cidx_d  = 4'd0;
      end
    endcase
    in_ready_d = (state_d == ST_WAIT);
    wreq_d     = (state_d != ST_WAIT);
  end

  // State and datapath registers, including the registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      cidx_q      <= 4'd0;
      col_q       <= COL_ZERO;
      offset_q    <= 9'd0;
      sec_start_q <= 1'b1;
      data_q      <= 8'h00;
      last_q      <= 1'b0;
      addr_q      <= 32'h0000_0000;
      in_ready_q  <= 1'b1;
      wreq_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cidx_q      <= cidx_d;
      col_q       <= col_d;
      offset_q    <= offset_d;
      sec_start_q <= sec_start_d;
      data_q      <= data_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      in_ready_q  <= in_ready_d;
      wreq_q      <= wreq_d;
    end
  end

  // Character mux: selects the ASCII code for the current state and index
  always_comb begin
    wdata_c = 8'h00;
    case (state_q)
      ST_HDR: begin
        case (cidx_q)
          4'd0:    wdata_c = SEC_STR[31:24];
          4'd1:    wdata_c = SEC_STR[23:16];
          4'd2:    wdata_c = SEC_STR[15:8];
          4'd3:    wdata_c = SEC_STR[7:0];
          4'd4:    wdata_c = hex2ascii(addr_q[31:28]);
          4'd5:    wdata_c = hex2ascii(addr_q[27:24]);
          4'd6:    wdata_c = hex2ascii(addr_q[23:20]);
          4'd7:    wdata_c = hex2ascii(addr_q[19:16]);
          4'd8:    wdata_c = hex2ascii(addr_q[15:12]);
          4'd9:    wdata_c = hex2ascii(addr_q[11:8]);
          4'd10:   wdata_c = hex2ascii(addr_q[7:4]);
          4'd11:   wdata_c = hex2ascii(addr_q[3:0]);
          4'd12:   wdata_c = ASC_CR;
          4'd13:   wdata_c = ASC_LF;
          default: wdata_c = 8'h00;
        endcase
      end
      ST_OFS: begin
        case (cidx_q)
          4'd0:    wdata_c = hex2ascii({3'b000, offset_q[8]});
          4'd1:    wdata_c = hex2ascii(offset_q[7:4]);
          4'd2:    wdata_c = hex2ascii(offset_q[3:0]);
          4'd3:    wdata_c = ASC_COLON;
          default: wdata_c = 8'h00;
        endcase
      end
      ST_BYTE: begin
        case (cidx_q)
          4'd0:    wdata_c = ASC_SP;
          4'd1:    wdata_c = hex2ascii(data_q[7:4]);
          4'd2:    wdata_c = hex2ascii(data_q[3:0]);
          default: wdata_c = 8'h00;
        endcase
      end
      ST_EOL: begin
        case (cidx_q)
          4'd0:    wdata_c = ASC_CR;
          4'd1:    wdata_c = ASC_LF;
          default: wdata_c = 8'h00;
        endcase
      end
      default: wdata_c = 8'h00;
    endcase
  end

  assign in_ready = in_ready_q;
  assign wreq     = wreq_q;
  assign wdata    = wdata_c;
  assign busy     = ~sec_start_q;

endmodule

// File: tb/tb_sector_hex_dump.sv
// Scoreboard bench for sector_hex_dump: stimulus pushes expected text into
// a queue, a negedge monitor grants characters and compares them in order.
module tb_sector_hex_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic [31:0] sector_addr;
  logic        wgnt;
  logic        sel;

  logic        in_ready_a, wreq_a, busy_a;
  logic [7:0]  wdata_a;
  logic        in_ready_b, wreq_b, busy_b;
  logic [7:0]  wdata_b;
  logic        in_ready, wreq, busy;
  logic [7:0]  wdata;
  logic        wgnt_a, wgnt_b, in_valid_a, in_valid_b;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [7:0]  exp_q[$];
  int          mode;
  int          budget;
  bit          stall_v;
  logic [7:0]  stall_d;
  int          m_col, m_off;
  bit          m_sec, m_hdr;

  always #5 clk = ~clk;

  assign wgnt_a     = wgnt & ~sel;
  assign wgnt_b     = wgnt & sel;
  assign in_valid_a = in_valid & ~sel;
  assign in_valid_b = in_valid & sel;
  assign in_ready   = sel ? in_ready_b : in_ready_a;
  assign wreq       = sel ? wreq_b : wreq_a;
  assign wdata      = sel ? wdata_b : wdata_a;
  assign busy       = sel ? busy_b : busy_a;

  sector_hex_dump #(.BYTES_PER_LINE(16), .HEADER_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .sector_addr(sector_addr),
    .wreq(wreq_a), .wgnt(wgnt_a), .wdata(wdata_a), .busy(busy_a));

  sector_hex_dump #(.BYTES_PER_LINE(16), .HEADER_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .sector_addr(sector_addr),
    .wreq(wreq_b), .wgnt(wgnt_b), .wdata(wdata_b), .busy(busy_b));

  a_gnt_a: assert property (@(posedge clk) disable iff (!rst_n) (wgnt_a |-> wreq_a))
    else begin n_fails++; $display("FAIL wgnt_without_wreq_a: wgnt=1 wreq=0, required wreq=1"); end
  a_gnt_b: assert property (@(posedge clk) disable iff (!rst_n) (wgnt_b |-> wreq_b))
    else begin n_fails++; $display("FAIL wgnt_without_wreq_b: wgnt=1 wreq=0, required wreq=1"); end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_crlf();
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_hex(input logic [31:0] v, input int nd);
    for (int i = nd - 1; i >= 0; i--) exp_q.push_back(hexc(v[i*4 +: 4]));
  endtask

  // Text-level model of the dump format for longer streams
  task automatic model_byte(input logic [7:0] d, input bit l, input logic [31:0] a);
    if (m_sec && m_hdr) begin
      push_str("SEC ");
      push_hex(a, 8);
      push_crlf();
    end
    if (m_col == 0) begin
      push_hex(32'(m_off), 3);
      exp_q.push_back(8'h3A);
    end
    exp_q.push_back(8'h20);
    push_hex({24'h0, d}, 2);
    m_sec = 1'b0;
    m_off = (m_off + 1) % 512;
    m_col++;
    if (m_col == 16 || l) begin
      push_crlf();
      m_col = 0;
      if (l) begin
        m_sec = 1'b1;
        m_off = 0;
      end
    end
  endtask

  task automatic issue_byte(input logic [7:0] d, input bit l, input logic [31:0] a, input bit hold);
    int t;
    bit done;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l; sector_addr = a;
    done = 1'b0; t = 0;
    while (!done && t < 2000) begin
      if (in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    chk("accept_timeout", {31'h0, done}, 32'd1);
    if (!hold) begin
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit l, input logic [31:0] a, input bit hold);
    model_byte(d, l, a);
    issue_byte(d, l, a, hold);
  endtask

  task automatic drain(input string name, input int lim);
    int t;
    bit idle;
    t = 0;
    idle = 1'b0;
    while (!idle && t < lim) begin
      @(negedge clk);
      t++;
      idle = (exp_q.size() == 0) && in_ready && !wreq;
    end
    if (!idle) $display("drain %s: %0d characters still expected", name, exp_q.size());
    chk(name, {31'h0, idle}, 32'd1);
  endtask

  // Monitor: grants characters, checks order, stall stability and idle outputs
  always @(negedge clk) begin
    bit g;
    if (!rst_n) begin
      wgnt    = 1'b0;
      stall_v = 1'b0;
    end else begin
      if (stall_v && wreq) chk("wdata_stable", {24'h0, wdata}, {24'h0, stall_d});
      stall_v = 1'b0;
      g = 1'b0;
      if (wreq) begin
        case (mode)
          0: g = 1'b1;
          1: g = ($urandom_range(99, 0) < 30);
          default: begin
            g = (budget > 0);
            if (g) budget--;
          end
        endcase
      end
      wgnt = g;
      if (g) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_char: got %h, required no character", wdata);
        end else begin
          chk("wdata_char", {24'h0, wdata}, {24'h0, exp_q.pop_front()});
        end
      end else if (wreq) begin
        stall_v = 1'b1;
        stall_d = wdata;
      end
      if (!wreq) chk("wdata_idle_zero", {24'h0, wdata}, 32'h0);
      if (in_ready) chk("no_wreq_while_ready", {31'h0, wreq}, 32'h0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    sector_addr = 32'h0; wgnt = 1'b0; sel = 1'b0; mode = 0; budget = 0;
    stall_v = 1'b0; stall_d = 8'h00;
    m_col = 0; m_off = 0; m_sec = 1'b1; m_hdr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_wreq", {31'h0, wreq}, 32'd0);
    chk("rst_wdata", {24'h0, wdata}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // One header sector, grants follow wreq
    push_str("SEC 00001A2B"); push_crlf(); push_str("000: DE AD BE"); push_crlf();
    issue_byte(8'hDE, 1'b0, 32'h0000_1A2B, 1'b0);
    issue_byte(8'hAD, 1'b0, 32'hFFFF_FFFF, 1'b0);
    #1 chk("busy_mid_sector", {31'h0, busy}, 32'd1);
    issue_byte(8'hBE, 1'b1, 32'hFFFF_FFFF, 1'b0);
    drain("drain_hdr_sector", 200);
    chk("busy_after_sector", {31'h0, busy}, 32'd0);

    // Same sector under 30% grant backpressure
    mode = 1;
    push_str("SEC 00001A2B"); push_crlf(); push_str("000: DE AD BE"); push_crlf();
    issue_byte(8'hDE, 1'b0, 32'h0000_1A2B, 1'b0);
    issue_byte(8'hAD, 1'b0, 32'h0000_1A2B, 1'b0);
    issue_byte(8'hBE, 1'b1, 32'h0000_1A2B, 1'b0);
    drain("drain_backpressure", 2000);
    mode = 0;

    // Short line ended by in_last, then a new sector restarts at 000
    push_str("SEC CAFE0001"); push_crlf(); push_str("000: 01 02 03 04 05"); push_crlf();
    for (int i = 1; i <= 5; i++) issue_byte(8'(i), (i == 5), 32'hCAFE_0001, 1'b0);
    push_str("SEC 00000002"); push_crlf(); push_str("000: AA BB"); push_crlf();
    issue_byte(8'hAA, 1'b0, 32'h0000_0002, 1'b0);
    issue_byte(8'hBB, 1'b1, 32'h0000_0002, 1'b0);
    drain("drain_short_line", 400);

    // Full 512-byte sector with header suppressed, then offset restart
    sel = 1'b1;
    m_col = 0; m_off = 0; m_sec = 1'b1; m_hdr = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++)
        send(8'(i), (s == 1 && i == 255), 32'h0000_0055, 1'b0);
    drain("drain_512", 20000);
    push_str("000: 7E"); push_crlf();
    issue_byte(8'h7E, 1'b1, 32'h0000_0056, 1'b0);
    drain("drain_after_512", 200);

    // Back-to-back sectors with in_valid held high throughout
    sel = 1'b0;
    @(negedge clk);
    m_col = 0; m_off = 0; m_sec = 1'b1; m_hdr = 1'b1;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 4; i++)
        send(8'(s * 16 + i), (i == 3),
             (s == 0) ? 32'h0000_0100 : (s == 1) ? 32'h0000_0200 : 32'hDEAD_BEEF,
             !(s == 2 && i == 3));
    drain("drain_back_to_back", 1000);

    // Reset while in BYTE with cidx=1
    mode = 2; budget = 19;
    push_str("SEC 0000ABCD"); push_crlf(); push_str("000: ");
    issue_byte(8'h5A, 1'b0, 32'h0000_ABCD, 1'b0);
    for (int t = 0; t < 100 && !(budget == 0 && exp_q.size() == 0); t++) @(negedge clk);
    @(negedge clk);
    chk("pre_reset_wreq", {31'h0, wreq}, 32'd1);
    chk("pre_reset_hi_nibble", {24'h0, wdata}, 32'h35);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_wreq", {31'h0, wreq}, 32'd0);
    chk("midreset_wdata", {24'h0, wdata}, 32'd0);
    chk("midreset_in_ready", {31'h0, in_ready}, 32'd1);
    chk("midreset_busy", {31'h0, busy}, 32'd0);
    rst_n = 1'b1;
    mode = 0;
    push_str("SEC 00000077"); push_crlf(); push_str("000: 42"); push_crlf();
    issue_byte(8'h42, 1'b1, 32'h0000_0077, 1'b0);
    drain("drain_after_reset", 200);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
